// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: valid/ready pipeline-stage buffer between NPC core stages.
// Holds up to DEPTH payload entries in a circular buffer. s_ready is derived
// only from occupancy, and m_data comes straight from storage, so the block
// cuts every combinational path between the two sides. BYPASS=1 turns it into
// a plain wire-through for single-cycle builds.
module pipe_stage_fifo #(
  parameter int WIDTH  = 160,
  parameter int DEPTH  = 2,
  parameter bit BYPASS = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (BYPASS) begin : g_bypass

    // Pure pass-through: no state, and clock/reset/flush do not touch the datapath.
    assign s_ready = m_ready;
    assign m_valid = s_valid;
    assign m_data  = s_data;
    assign count   = '0;

    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, flush};

  end else begin : g_buffer

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rp;
    logic [PTR_W-1:0] r_wp;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly, so DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A slot that a pop frees up is offered to upstream only on the next cycle.
    // This keeps m_ready out of the s_ready logic.
    assign s_ready = !rst && !flush && (r_count < FULL_CNT);
    assign m_valid = (r_count != '0);
    assign m_data  = r_mem[r_rp];
    assign count   = r_count;

    assign w_push  = s_valid && s_ready;
    assign w_pop   = m_valid && m_ready;

    // Buffer state: reset clears everything, flush empties, otherwise push/pop bookkeeping.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // read in this block sees the value from before the clock edge.
      if (rst) begin
        r_rp    <= '0;
        r_wp    <= '0;
        r_count <= '0;
        // NOTE: storage is cleared on reset on purpose, so that m_data reads 0
        // after reset. Flush leaves the contents stale, because m_valid=0
        // already hides them from downstream.
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
      end else if (flush) begin
        r_rp    <= '0;
        r_wp    <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wp] <= s_data;
          r_wp        <= ptr_next(r_wp);
        end
        if (w_pop) begin
          r_rp <= ptr_next(r_rp);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: directed bench for pipe_stage_fifo.
// It drives four instances: DEPTH=2, DEPTH=4, DEPTH=1, and BYPASS.
// A vector table covers the DEPTH=2 handshake. Hand-written sequences cover
// streaming, flush, reset, half-throughput and bypass behaviour.
module tb_pipe_stage_fifo;

  localparam int W = 8;

  logic clk;
  logic rst;

  // DEPTH=2 instance
  logic         f2, sv2, sr2, mv2, mr2;
  logic [W-1:0] sd2, md2;
  logic [1:0]   c2;
  // DEPTH=4 instance
  logic         f4, sv4, sr4, mv4, mr4;
  logic [W-1:0] sd4, md4;
  logic [2:0]   c4;
  // DEPTH=1 instance
  logic         f1, sv1, sr1, mv1, mr1;
  logic [W-1:0] sd1, md1;
  logic [0:0]   c1;
  // BYPASS instance
  logic         fb, svb, srb, mvb, mrb;
  logic [W-1:0] sdb, mdb;
  logic [1:0]   cb;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(2), .BYPASS(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .flush(f2), .s_valid(sv2), .s_ready(sr2), .s_data(sd2),
    .m_valid(mv2), .m_ready(mr2), .m_data(md2), .count(c2));

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(4), .BYPASS(1'b0)) u_d4 (
    .clk(clk), .rst(rst), .flush(f4), .s_valid(sv4), .s_ready(sr4), .s_data(sd4),
    .m_valid(mv4), .m_ready(mr4), .m_data(md4), .count(c4));

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(1), .BYPASS(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .flush(f1), .s_valid(sv1), .s_ready(sr1), .s_data(sd1),
    .m_valid(mv1), .m_ready(mr1), .m_data(md1), .count(c1));

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(2), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .flush(fb), .s_valid(svb), .s_ready(srb), .s_data(sdb),
    .m_valid(mvb), .m_ready(mrb), .m_data(mdb), .count(cb));

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog, so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 unit after the rising edge; outputs are sampled 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         sv;
    logic [W-1:0] d;
    logic         mr;
    logic         fl;
    logic         sr;
    logic         mv;
    logic [W-1:0] md;
    logic         chk_d;
    logic [1:0]   cnt;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  initial begin
    // Expected values are the outputs seen during the cycle in which the inputs are applied.
    //            sv    d      mr    fl    sr    mv    md     chk   cnt
    tbl[0]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0}; // push A
    tbl[1]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 2'd1}; // push B
    tbl[2]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 2'd2}; // full, C refused
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 2'd2}; // pop A while full
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1, 2'd1}; // slot freed
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1, 2'd1}; // pop B
    tbl[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0}; // push 0x11
    tbl[7]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 2'd1}; // push+pop at count 1
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1}; // 0x22 at head
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1}; // pop 0x22
    tbl[10] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0}; // flush blocks push
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0}; // nothing entered

    // NOTE: the bench drives stimulus with blocking assignments from this
    // process, offset from the clock edge, so there is no race with the DUT's
    // non-blocking updates.
    rst = 1'b1;
    {f2, sv2, mr2, sd2} = '0;
    {f4, sv4, mr4, sd4} = '0;
    {f1, sv1, mr1, sd1} = '0;
    {fb, svb, mrb, sdb} = '0;
    step();
    sv2 = 1'b1;
    #2;
    check("d2_sready_in_reset", sr2, 0);
    step();
    sv2 = 1'b0;
    rst = 1'b0;
    #2;
    check("d2_reset_count", c2, 0);
    check("d2_reset_mvalid", mv2, 0);
    check("d2_reset_mdata", md2, 0);

    // DEPTH=2 handshake table
    for (int i = 0; i < NV; i++) begin
      sv2 = tbl[i].sv;
      sd2 = tbl[i].d;
      mr2 = tbl[i].mr;
      f2  = tbl[i].fl;
      #2;
      check($sformatf("d2_vec%0d_sready", i), sr2, tbl[i].sr);
      check($sformatf("d2_vec%0d_mvalid", i), mv2, tbl[i].mv);
      check($sformatf("d2_vec%0d_count", i), c2, tbl[i].cnt);
      if (tbl[i].chk_d) check($sformatf("d2_vec%0d_mdata", i), md2, tbl[i].md);
      step();
    end
    f2 = 1'b0;

    // DEPTH=2 continuous streaming of 1..20 with m_ready held high
    mr2 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      sv2 = 1'b1;
      sd2 = W'(i);
      #2;
      check($sformatf("stream_sready_%0d", i), sr2, 1);
      if (i > 1) begin
        check($sformatf("stream_mvalid_%0d", i), mv2, 1);
        check($sformatf("stream_mdata_%0d", i), md2, i - 1);
      end
      step();
    end
    sv2 = 1'b0;
    #2;
    check("stream_last_mdata", md2, 20);
    check("stream_last_mvalid", mv2, 1);
    step();
    #2;
    check("stream_drained", mv2, 0);

    // DEPTH=4: fill, then flush while upstream keeps pushing
    mr4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sv4 = 1'b1;
      sd4 = W'(8'h41 + i);
      #2;
      check($sformatf("d4_fill_sready_%0d", i), sr4, 1);
      step();
    end
    sd4 = 8'h99;
    f4  = 1'b1;
    #2;
    check("d4_full_count", c4, 4);
    check("d4_flush_sready", sr4, 0);
    step();
    f4  = 1'b0;
    sd4 = 8'h55;
    #2;
    check("d4_post_flush_count", c4, 0);
    check("d4_post_flush_mvalid", mv4, 0);
    check("d4_post_flush_sready", sr4, 1);
    step();
    sv4 = 1'b0;
    #2;
    check("d4_new_mvalid", mv4, 1);
    check("d4_new_mdata", md4, 8'h55);
    check("d4_new_count", c4, 1);
    mr4 = 1'b1;
    step();
    mr4 = 1'b0;
    #2;
    check("d4_new_popped", c4, 0);

    // DEPTH=4: three pushes, then a synchronous reset
    for (int i = 0; i < 3; i++) begin
      sv4 = 1'b1;
      sd4 = W'(8'h61 + i);
      step();
    end
    sv4 = 1'b0;
    #2;
    check("d4_pre_reset_count", c4, 3);
    rst = 1'b1;
    #2;
    check("d4_sready_in_reset", sr4, 0);
    step();
    rst = 1'b0;
    sv4 = 1'b1;
    sd4 = 8'h07;
    #2;
    check("d4_post_reset_count", c4, 0);
    check("d4_post_reset_mvalid", mv4, 0);
    check("d4_post_reset_mdata", md4, 0);
    step();
    sv4 = 1'b0;
    #2;
    check("d4_after_reset_mdata", md4, 8'h07);
    check("d4_after_reset_mvalid", mv4, 1);

    // DEPTH=1: under continuous traffic the stage alternates between accepting and presenting
    mr1 = 1'b1;
    sv1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sd1 = W'(8'h10 + k / 2);
      #2;
      check($sformatf("d1_sready_%0d", k), sr1, (k % 2 == 0));
      check($sformatf("d1_mvalid_%0d", k), mv1, (k % 2 == 1));
      if (k % 2 == 1) check($sformatf("d1_mdata_%0d", k), md1, 8'h10 + (k - 1) / 2);
      step();
    end
    sv1 = 1'b0;

    // BYPASS: pure combinational pass-through, unaffected by flush and reset
    for (int k = 0; k < 4; k++) begin
      svb = k[0];
      mrb = k[1];
      sdb = W'(8'h3C ^ (k * 8'h11));
      fb  = (k == 2);
      rst = (k == 3);
      #1;
      check($sformatf("byp_mdata_%0d", k), mdb, 8'h3C ^ (k * 8'h11));
      check($sformatf("byp_mvalid_%0d", k), mvb, k % 2);
      check($sformatf("byp_sready_%0d", k), srb, k / 2);
      check($sformatf("byp_count_%0d", k), cb, 0);
      step();
    end
    rst = 1'b0;
    fb  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
